// File: rtl/seq_pattern_detector_if.sv
// Signal bundle for seq_pattern_detector: configuration, serial input and detect/count outputs.
// The master drives configuration and data; the detector sits on the slave modport.
interface seq_pattern_detector_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 16
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap_en;
  logic               din;
  logic               din_valid;
  logic               cnt_clr;
  logic               detect;
  logic               busy;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_load, pattern, pat_len, overlap_en, din, din_valid, cnt_clr,
    input  detect, busy, match_count
  );

  modport slave (
    input  cfg_load, pattern, pat_len, overlap_en, din, din_valid, cnt_clr,
    output detect, busy, match_count
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector with overlapping/non-overlapping search.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_pattern_detector #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_pattern_detector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               detect_q, detect_d;

  logic [MAX_LEN-1:0] hist_next, mask;
  logic [LEN_W-1:0]   fill_next, len_clamped;
  logic               accept, match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hist_q   <= '0;
      fill_q   <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      detect_q <= detect_d;
    end
  end

  // Datapath: candidate history/fill and the masked comparison against the active pattern.
  always_comb begin
    accept      = bus.din_valid && (state_q != StIdle);
    hist_next   = {hist_q[MAX_LEN-2:0], bus.din};
    fill_next   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    len_clamped = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    match = (len_q != '0) && (fill_next >= len_q) && ((hist_next & mask) == (pat_q & mask));
  end

  // Next state: cfg_load takes priority over any bit presented in the same cycle.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    if (bus.cfg_load) begin
      pat_d   = bus.pattern;
      len_d   = len_clamped;
      ovl_d   = bus.overlap_en;
      hist_d  = '0;
      fill_d  = '0;
      state_d = (len_clamped == '0) ? StIdle : StFill;
    end else if (accept) begin
      hist_d = hist_next;
      fill_d = fill_next;
      if (match && !ovl_q) begin
        fill_d  = '0;
        state_d = StFill;
      end else if (fill_next >= len_q) begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    detect_d = !bus.cfg_load && accept && match;
    bus.busy = (state_q != StIdle);
  end

  assign bus.detect = detect_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (detect_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr  = bus.cnt_clr;
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: directed scenarios plus randomized traffic,
// checked against a bit-list reference model; honours SEQ_DET_MATCH_CNT_EN.
module tb_seq_pattern_detector;
  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = 4;
  localparam int unsigned CntW   = 2;
  localparam int          CntMax = 3;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct packed {
    logic            det;
    logic            busy;
    logic [CntW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_pattern_detector_if #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(CntW)) bus ();

  seq_pattern_detector #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(CntW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  // Reference model: list of accepted bits since the last restart.
  bit         m_bits[$];
  bit [7:0]   m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_active;
  int         m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat    = '0;
    m_len    = 0;
    m_ovl    = 1'b0;
    m_active = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic drive(input bit cl, input bit [7:0] p, input int l, input bit o,
                       input bit d, input bit v, input bit clr);
    bit   hit;
    exp_t e;
    @(negedge clk);
    bus.cfg_load   = cl;
    bus.pattern    = p;
    bus.pat_len    = LenW'(l);
    bus.overlap_en = o;
    bus.din        = d;
    bus.din_valid  = v;
    bus.cnt_clr    = clr;
    hit = 1'b0;
    if (cl) begin
      m_bits.delete();
      m_pat    = p;
      m_len    = (l > MaxLen) ? MaxLen : l;
      m_ovl    = o;
      m_active = (m_len != 0);
    end else if (v && m_active) begin
      m_bits.push_back(d);
      if (m_bits.size() > MaxLen) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CntMax) m_cnt++;
    e.det  = hit;
    e.busy = m_active;
    e.cnt  = CntEn ? CntW'(m_cnt) : '0;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_detect", int'(bus.detect), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_count", int'(bus.match_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every registered output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("detect", int'(bus.detect), int'(e.det));
        chk("busy", int'(bus.busy), int'(e.busy));
        chk("match_count", int'(bus.match_count), int'(e.cnt));
      end
    end
  end

  initial begin
    bit [7:0] a5;
    rst_n = 1'b0;
    bus.cfg_load = 0; bus.pattern = '0; bus.pat_len = '0; bus.overlap_en = 0;
    bus.din = 0; bus.din_valid = 0; bus.cnt_clr = 0;
    model_reset();
    #3;
    chk("por_detect", int'(bus.detect), 0);
    chk("por_busy", int'(bus.busy), 0);
    chk("por_count", int'(bus.match_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // No configuration: stream of ones must never detect.
    for (int i = 0; i < 6; i++) drive(0, 8'h00, 0, 0, 1, 1, 0);

    // 101 overlapping; load cycle carries a valid bit that must be dropped.
    drive(1, 8'b101, 3, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 8'b101, 3, 1, ~i[0], 1, 0);
    idle(2);

    // 101 non-overlapping.
    drive(0, 8'h00, 0, 0, 0, 0, 1);
    drive(1, 8'b101, 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 8'b101, 3, 0, ~i[0], 1, 0);
    idle(2);

    // A5 length 8 with two idle cycles between valid bits.
    a5 = 8'hA5;
    drive(1, a5, 8, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) begin
      drive(0, a5, 8, 0, a5[i], 1, 0);
      idle(2);
    end

    // Restart after two bits of 101, concurrent with a valid bit.
    drive(1, 8'b101, 3, 1, 0, 0, 0);
    drive(0, 8'b101, 3, 1, 1, 1, 0);
    drive(0, 8'b101, 3, 1, 0, 1, 0);
    drive(1, 8'b101, 3, 1, 1, 1, 0);
    drive(0, 8'b101, 3, 1, 0, 1, 0);
    drive(0, 8'b101, 3, 1, 1, 1, 0);
    drive(0, 8'b101, 3, 1, 1, 1, 0);
    drive(0, 8'b101, 3, 1, 0, 1, 0);
    drive(0, 8'b101, 3, 1, 1, 1, 0);

    // Length 1: every matching bit detects; counter saturates; clear beats a match.
    drive(0, 8'h00, 0, 0, 0, 0, 1);
    drive(1, 8'h01, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 8'h01, 1, 1, 1, 1, 0);
    drive(0, 8'h01, 1, 1, 1, 1, 1);
    drive(0, 8'h01, 1, 1, 0, 1, 0);

    // Over-length clamps to MaxLen; zero length returns to idle.
    drive(1, 8'hFF, 15, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 8'hFF, 15, 1, 1, 1, 0);
    drive(1, 8'h00, 0, 0, 1, 1, 0);
    drive(0, 8'h00, 0, 0, 0, 1, 0);

    do_reset();
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      int  l;
      bit  cl;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cl = ($urandom_range(0, 39) == 0);
        l  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(1, 4));
        drive(cl, 8'($urandom), l, 1'($urandom), 1'($urandom),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
      end
    end

    idle(1);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
